// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: machine word size, NOP encoding and the
// fetch buffer entry layout.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and the
// valid/ready hand-off to decode.
interface inst_fetch_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rd_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    modport master (
        output imem_req, imem_addr,
        input  imem_rd_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_inst,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rd_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_inst,
        output out_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, inst} entries between the memory response and
// decode; flush empties it in one cycle.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    overflow_check: assert property (@(posedge clk) disable iff (reset || flush)
        !(push && !pop && count == CNT_W'(BUF_DEPTH)));

    underflow_check: assert property (@(posedge clk) disable iff (reset || flush)
        !(pop && count == '0));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency word reads and
// queues responses for decode; a redirect flushes everything fetched so far.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    inst_fetch_if.master  bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             valid;
    logic             accept;
    logic             push;
    logic             pop;
    logic             issue;

    // A redirect wins over both the pop and any response arriving this cycle.
    assign valid      = !reset && (count != '0);
    assign accept     = valid && bus.out_ready;
    assign pop        = accept && !bus.redirect_valid;
    assign push       = inflight && !bus.redirect_valid;
    assign push_entry = '{pc: req_pc, inst: bus.imem_rd_data};

    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, accept};
    assign issue     = !reset && !bus.redirect_valid && (occupancy < (CNT_W+1)'(BUF_DEPTH));

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.out_valid = valid;
    assign bus.out_pc    = reset ? RESET_PC : (valid ? head.pc : pc);
    assign bus.out_inst  = valid ? head.inst : NOP_INST;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc       <= word_align(bus.redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + XLEN'(INST_BYTES);
            end
        end
    end

    fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .count      (count),
        .head       (head)
    );

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage between the synchronous instruction memory and the CPU decode stage.
- Owns the program counter and issues word reads to instruction memory.
- Buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all fetched and in-flight instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
BUF_DEPTH, 2, fetch buffer entries; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  read request this cycle
imem_addr  out  32  byte address of requested word, always word-aligned
imem_rd_data  in  32  read data; valid exactly one cycle after the cycle imem_req=1
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch PC; bits [1:0] ignored, treated as 0
out_valid  out  1  buffer head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_pc  out  32  PC of head instruction
out_inst  out  32  head instruction word

Behaviour:
- Reset (wins over everything):
  - pc <= RESET_PC; buffer count 0; in-flight flag 0.
  - imem_req=0 while reset=1; out_valid=0; out_pc=RESET_PC; out_inst=NOP (32'h0000_0013).
- Memory interface: fixed 1-cycle latency, no backpressure. The block tracks at most one in-flight request via the inflight flag.
- Issue rule, evaluated per cycle:
  - pop = out_valid & out_ready.
  - imem_req = !reset & !redirect_valid & (count + inflight - pop < BUF_DEPTH).
  - imem_addr = pc.
  - On issue: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Combinational path out_ready -> imem_req is intended.
- Response: in the cycle after an issue, {pc_of_request, imem_rd_data} is written to the buffer tail at the clock edge. It becomes visible at the head no earlier than the following cycle; there is no bypass.
- Latency:
  - First cycle with reset=0 is cycle 0.
  - imem_req=1 with addr RESET_PC in cycle 0; data in cycle 1; out_valid=1 in cycle 2.
- Throughput: one instruction per cycle sustained with BUF_DEPTH=2 and out_ready held 1.
- Stall: while out_valid=1 and out_ready=0, out_pc and out_inst hold stable. The buffer fills to BUF_DEPTH, then issue stops with no loss.
- Redirect in cycle N:
  - Buffer emptied at end of N.
  - Any response arriving in N is discarded; no request issued in N.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Request at the target in N+1, data N+2, out_valid=1 in N+3.
  - out_valid may still be 1 during N itself; decode must ignore it.
- Simultaneous events:
  - Redirect + pop: redirect wins and the pop is ignored; the buffer is flushed anyway.
  - Redirect + response: the response is dropped.
  - Push + pop on a full buffer cannot occur by the issue rule. Push + pop at any other occupancy keeps count unchanged.
- Reset mid-operation: any in-flight response in the cycle after reset is discarded. The inflight flag is cleared by reset.
- Buffer pointers wrap modulo BUF_DEPTH. count ranges 0..BUF_DEPTH, and an assertion flags overflow/underflow.
- out_inst = NOP whenever out_valid=0.

Decomposition:
- Shared package (riscv_pkg): XLEN=32, INST_BYTES=4, NOP_INST=32'h0000_0013, default RESET_PC.
- Sub-module fetch_buffer:
  - Synchronous FIFO of {pc, inst} entries, parameter BUF_DEPTH.
  - Ports: push, pop, flush, count, head data.
- inst_fetch holds the PC, issue logic, inflight flag and redirect handling.

Test Plan:
- Reset release, out_ready=1, memory word at addr k = 32'h1000_0000+k: imem_addr 0,4,8,... from cycle 0; out_valid from cycle 2; out_pc 0,4,8 with matching out_inst, one per cycle.
- out_ready=0 from cycle 2 for 5 cycles: out_pc stays 0; imem_req drops after buffer holds 2 entries; release -> out_pc 0,4,8,... with no gaps or duplicates.
- Redirect to 32'h0000_0103 while buffer full and request in flight: out_valid=0 at N+1; next accepted instruction has out_pc=32'h0000_0100, at N+3; no pre-redirect PCs appear afterward.
- Redirect and out_ready=1 in the same cycle, plus a response arriving that cycle: response discarded, pop ignored, next out_pc = redirect target.
- RESET_PC=32'hFFFF_FFF8, out_ready=1: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert reset mid-stream for one cycle with a request in flight: out_valid=0 during and after reset until cycle 2 after release; first out_pc=RESET_PC; stale response never appears.
